// File: rtl/digit_classifier_if.sv
// digit_classifier_if
// Bundles the image-loader handshake, the weight ROM port and the result
// outputs of digit_classifier. The master side is the surrounding system
// (image loader plus weight ROM); the slave side is the classifier.
interface digit_classifier_if #(
  parameter int WIDTH = 8,
  parameter int PIX_W = 28,
  parameter int PIX_H = 28,
  parameter int ACC_W = 26,
  parameter int AW    = 14
);

  // Loader side: flat pixel vector, pixel 0 in the MSBs.
  logic [WIDTH*PIX_H*PIX_W-1:0] image;
  logic                         valid;

  // Weight ROM: registered address out, signed weight back one cycle later.
  logic [AW-1:0]                w_addr;
  logic [7:0]                   w_data;

  // Status and result.
  logic                         busy;
  logic                         done;
  logic [3:0]                   digit;
  logic [ACC_W-1:0]             score;

  modport master (
    output image, valid, w_data,
    input  w_addr, busy, done, digit, score
  );

  modport slave (
    input  image, valid, w_data,
    output w_addr, busy, done, digit, score
  );

endinterface

// File: rtl/digit_classifier.sv
// digit_classifier
// Captures a flat PIX_W x PIX_H image on the loader's valid pulse, then for
// each class computes the dot product of the pixels with a signed weight set
// streamed from an external synchronous ROM (one weight per cycle). The
// highest-scoring class (lowest index on ties) and its score are published
// with a one-cycle done pulse.
module digit_classifier #(
  parameter int WIDTH   = 8,
  parameter int PIX_W   = 28,
  parameter int PIX_H   = 28,
  parameter int CLASSES = 10,
  parameter int ACC_W   = 26,
  parameter int AW      = 14
) (
  input  logic              clk,
  input  logic              reset,
  digit_classifier_if.slave bus
);

  localparam int N      = PIX_W * PIX_H;
  localparam int TOTAL  = CLASSES * N;
  localparam int PIX_IW = (N > 1) ? $clog2(N) : 1;
  localparam int PB_W   = $clog2(WIDTH * N);
  // Zero-extended pixel (WIDTH+1 signed) times 8-bit signed weight.
  localparam int PROD_W = WIDTH + 9;

  localparam logic [AW-1:0]           LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [PIX_IW-1:0]       LAST_PIX  = PIX_IW'(N - 1);
  localparam logic signed [ACC_W-1:0] MOST_NEG  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    CMP   = 2'd3
  } state_t;

  state_t state;

  // Address generator: the ROM address plus the pixel/class it refers to.
  logic [AW-1:0]     addr;
  logic [PIX_IW-1:0] pix_idx;
  logic [3:0]        cls_idx;

  // The same pixel/class one cycle later, aligned with the returning w_data.
  logic              data_valid;
  logic [PIX_IW-1:0] pix_d;
  logic [3:0]        cls_d;

  // Captured image and arithmetic state.
  logic [WIDTH*N-1:0]       img;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  best_score;
  logic [3:0]               best_idx;

  // Registered outputs.
  logic              busy_flag;
  logic              done_flag;
  logic [3:0]        digit_hold;
  logic [ACC_W-1:0]  score_hold;

  // Combinational datapath.
  logic [PB_W-1:0]          pix_base;
  logic [WIDTH-1:0]         pix_val;
  logic [PROD_W-1:0]        pix_ext;
  logic [PROD_W-1:0]        w_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;

  assign bus.w_addr = addr;
  assign bus.busy   = busy_flag;
  assign bus.done   = done_flag;
  assign bus.digit  = digit_hold;
  assign bus.score  = score_hold;

  // Select the pixel paired with w_data, form the product and the next sum.
  always_comb begin
    pix_base = PB_W'(((N - 1) - int'(pix_d)) * WIDTH);
    pix_val  = img[pix_base +: WIDTH];
    pix_ext  = {{(PROD_W-WIDTH){1'b0}}, pix_val};
    w_ext    = {{(PROD_W-8){bus.w_data[7]}}, bus.w_data};
    prod     = $signed(pix_ext) * $signed(w_ext);
    sum      = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Run sequencing: state, ROM address stepping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      pix_idx    <= '0;
      cls_idx    <= 4'd0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
      digit_hold <= 4'd0;
      score_hold <= '0;
    end else begin
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            state     <= MAC;
            busy_flag <= 1'b1;
            addr      <= '0;
            pix_idx   <= '0;
            cls_idx   <= 4'd0;
          end
        end
        MAC: begin
          if (addr == LAST_ADDR) begin
            // Last address is out; wait for its data to come back.
            state <= DRAIN;
          end else begin
            addr <= addr + AW'(1);
            if (pix_idx == LAST_PIX) begin
              pix_idx <= '0;
              cls_idx <= cls_idx + 4'd1;
            end else begin
              pix_idx <= pix_idx + PIX_IW'(1);
            end
          end
        end
        DRAIN: begin
          state <= CMP;
        end
        CMP: begin
          // best_* already include the final class comparison.
          state      <= IDLE;
          busy_flag  <= 1'b0;
          done_flag  <= 1'b1;
          digit_hold <= best_idx;
          score_hold <= best_score;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay the address's pixel/class by one cycle to meet the ROM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid <= 1'b0;
      pix_d      <= '0;
      cls_d      <= 4'd0;
    end else begin
      data_valid <= (state == MAC);
      pix_d      <= pix_idx;
      cls_d      <= cls_idx;
    end
  end

  // Image capture, per-class accumulation and running arg-max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img        <= '0;
      acc        <= '0;
      best_score <= MOST_NEG;
      best_idx   <= 4'd0;
    end else if (state == IDLE && bus.valid) begin
      img        <= bus.image;
      acc        <= '0;
      best_score <= MOST_NEG;
      best_idx   <= 4'd0;
    end else if (data_valid) begin
      if (pix_d == LAST_PIX) begin
        // Class complete: restart the sum and keep it only if strictly better.
        acc <= '0;
        if (sum > best_score) begin
          best_score <= sum;
          best_idx   <= cls_d;
        end
      end else begin
        acc <= sum;
      end
    end
  end

endmodule
